// File: rtl/native_mem_ram_bridge.sv
// rtl/native_mem_ram_bridge.sv - picorv32 native memory responder driving a dual-port block RAM
module native_mem_ram_bridge #(
  parameter int          AWIDTH    = 7,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic              mem_err,
  output logic              ram_wren,
  output logic [AWIDTH-1:0] ram_wraddr,
  output logic [31:0]       ram_di,
  output logic              ram_rden,
  output logic [AWIDTH-1:0] ram_rdaddr,
  input  logic [31:0]       ram_do
);

  typedef enum logic [2:0] {IDLE, RD1, RD2, PW1, PW2, ACK} state_t;

  state_t            state, state_n;
  logic [AWIDTH-1:0] idx_q, idx_n;
  logic [31:0]       wdata_q, wdata_n;
  logic [3:0]        wstrb_q, wstrb_n;

  logic              mem_ready_n, mem_err_n, ram_wren_n, ram_rden_n;
  logic [31:0]       mem_rdata_n, ram_di_n;
  logic [AWIDTH-1:0] ram_wraddr_n, ram_rdaddr_n;

  logic [AWIDTH-1:0] idx;
  logic              in_win;
  logic              unused_ok;

  assign idx       = mem_addr[AWIDTH+1:2];
  assign in_win    = (mem_addr[31:AWIDTH+2] == ADDR_BASE[31:AWIDTH+2]);
  assign unused_ok = ^{mem_instr, mem_addr[1:0]};

  always_comb begin
    state_n      = state;
    idx_n        = idx_q;
    wdata_n      = wdata_q;
    wstrb_n      = wstrb_q;
    mem_ready_n  = 1'b0;
    mem_err_n    = 1'b0;
    ram_wren_n   = 1'b0;
    ram_rden_n   = 1'b0;
    mem_rdata_n  = mem_rdata;
    ram_di_n     = ram_di;
    ram_wraddr_n = ram_wraddr;
    ram_rdaddr_n = ram_rdaddr;
    case (state)
      IDLE: begin
        // mem_ready is still high in the CPU's view during the turnaround cycle
        if (mem_valid && !mem_ready) begin
          idx_n   = idx;
          wdata_n = mem_wdata;
          wstrb_n = mem_wstrb;
          if (!in_win) begin
            mem_ready_n = 1'b1;
            mem_err_n   = 1'b1;
            mem_rdata_n = 32'h0;
            state_n     = ACK;
          end else if (mem_wstrb == 4'h0) begin
            ram_rden_n   = 1'b1;
            ram_rdaddr_n = idx;
            state_n      = RD1;
          end else if (mem_wstrb == 4'hF) begin
            ram_wren_n   = 1'b1;
            ram_wraddr_n = idx;
            ram_di_n     = mem_wdata;
            mem_ready_n  = 1'b1;
            state_n      = ACK;
          end else begin
            ram_rden_n   = 1'b1;
            ram_rdaddr_n = idx;
            state_n      = PW1;
          end
        end
      end
      RD1: state_n = RD2;
      RD2: begin
        mem_rdata_n = ram_do;
        mem_ready_n = 1'b1;
        state_n     = ACK;
      end
      PW1: state_n = PW2;
      PW2: begin
        for (int i = 0; i < 4; i++)
          ram_di_n[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : ram_do[8*i +: 8];
        ram_wren_n   = 1'b1;
        ram_wraddr_n = idx_q;
        mem_ready_n  = 1'b1;
        state_n      = ACK;
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx_q      <= '0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      mem_ready  <= 1'b0;
      mem_err    <= 1'b0;
      ram_wren   <= 1'b0;
      ram_rden   <= 1'b0;
      mem_rdata  <= 32'h0;
      ram_di     <= 32'h0;
      ram_wraddr <= '0;
      ram_rdaddr <= '0;
    end else begin
      state      <= state_n;
      idx_q      <= idx_n;
      wdata_q    <= wdata_n;
      wstrb_q    <= wstrb_n;
      mem_ready  <= mem_ready_n;
      mem_err    <= mem_err_n;
      ram_wren   <= ram_wren_n;
      ram_rden   <= ram_rden_n;
      mem_rdata  <= mem_rdata_n;
      ram_di     <= ram_di_n;
      ram_wraddr <= ram_wraddr_n;
      ram_rdaddr <= ram_rdaddr_n;
    end
  end

endmodule

// File: tb/tb_native_mem_ram_bridge.sv
// tb/tb_native_mem_ram_bridge.sv - directed bench for native_mem_ram_bridge with a behavioral RAM
module tb_native_mem_ram_bridge;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_valid, mem_instr;
  logic [31:0]   mem_addr, mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready, mem_err;
  logic [31:0]   mem_rdata;
  logic          ram_wren, ram_rden;
  logic [AW-1:0] ram_wraddr, ram_rdaddr;
  logic [31:0]   ram_di;
  logic [31:0]   ram_do = 32'h0;

  logic [31:0]   ram [0:(1<<AW)-1];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_data = 32'h0;
  int            ready_cnt = 0;
  int            wren_cnt = 0;
  int            checks = 0;
  int            errors = 0;

  native_mem_ram_bridge #(.AWIDTH(AW), .ADDR_BASE(32'h0)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .ram_wren(ram_wren), .ram_wraddr(ram_wraddr), .ram_di(ram_di),
    .ram_rden(ram_rden), .ram_rdaddr(ram_rdaddr), .ram_do(ram_do)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    if (ram_wren) ram[ram_wraddr] <= ram_di;
    if (ram_rden) ram_do <= ram[ram_rdaddr];
    if (mem_ready) ready_cnt <= ready_cnt + 1;
    if (ram_wren) wren_cnt <= wren_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [31:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    step();
    bd_we = 1'b0;
  endtask

  task automatic request(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    step(); step();
    checks++;
    if ({mem_ready, mem_err, ram_wren, ram_rden, mem_rdata, ram_di, ram_wraddr, ram_rdaddr} !== '0) begin
      errors++; $display("FAIL reset_outputs got rdy=%b err=%b wr=%b rd=%b rdata=%h di=%h", mem_ready, mem_err, ram_wren, ram_rden, mem_rdata, ram_di);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_read();
    poke(7'd5, 32'hDEADBEEF);
    request(32'h14, 32'h0, 4'h0);
    mem_instr = 1'b1;
    step(); // after E0
    checks++;
    if ({ram_rden, ram_wren, mem_ready, ram_rdaddr} !== {3'b100, 7'd5}) begin
      errors++; $display("FAIL read_E0 got rd=%b wr=%b rdy=%b rdaddr=%0d exp rd=1 wr=0 rdy=0 rdaddr=5", ram_rden, ram_wren, mem_ready, ram_rdaddr);
    end
    step(); // after E1
    checks++;
    if ({ram_rden, mem_ready} !== 2'b00) begin
      errors++; $display("FAIL read_E1 got rd=%b rdy=%b exp 0 0", ram_rden, mem_ready);
    end
    step(); // after E2
    checks++;
    if ({mem_ready, mem_err, mem_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      errors++; $display("FAIL read_E2 got rdy=%b err=%b rdata=%h exp 1 0 deadbeef", mem_ready, mem_err, mem_rdata);
    end
    step(); // after E3
    checks++;
    if ({mem_ready, ram_rden, mem_rdata} !== {2'b00, 32'hDEADBEEF}) begin
      errors++; $display("FAIL read_E3 got rdy=%b rd=%b rdata=%h exp 0 0 deadbeef", mem_ready, ram_rden, mem_rdata);
    end
    mem_valid = 1'b0; mem_instr = 1'b0;
    step();
  endtask

  task automatic test_full_write();
    request(32'h20, 32'h12345678, 4'hF);
    step(); // after E0
    checks++;
    if ({ram_wren, ram_rden, mem_ready, mem_err, ram_wraddr, ram_di} !== {4'b1010, 7'd8, 32'h12345678}) begin
      errors++; $display("FAIL fw_E0 got wr=%b rd=%b rdy=%b err=%b wraddr=%0d di=%h exp 1 0 1 0 8 12345678", ram_wren, ram_rden, mem_ready, mem_err, ram_wraddr, ram_di);
    end
    step(); // after E1: valid still held, turnaround
    checks++;
    if ({ram_wren, ram_rden, mem_ready, ram[8]} !== {3'b000, 32'h12345678}) begin
      errors++; $display("FAIL fw_E1 got wr=%b rd=%b rdy=%b ram8=%h exp 0 0 0 12345678", ram_wren, ram_rden, mem_ready, ram[8]);
    end
    checks++;
    if (mem_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL fw_rdata_hold got %h exp deadbeef", mem_rdata);
    end
    request(32'h20, 32'h0, 4'h0);
    step(); // after E2: earliest second acceptance
    checks++;
    if ({ram_rden, ram_rdaddr} !== {1'b1, 7'd8}) begin
      errors++; $display("FAIL fw_second_accept got rd=%b rdaddr=%0d exp 1 8", ram_rden, ram_rdaddr);
    end
    step(); step(); // after E4
    checks++;
    if ({mem_ready, mem_rdata} !== {1'b1, 32'h12345678}) begin
      errors++; $display("FAIL fw_readback got rdy=%b rdata=%h exp 1 12345678", mem_ready, mem_rdata);
    end
    step();
    mem_valid = 1'b0;
    step();
  endtask

  task automatic test_partial_write();
    int w0;
    poke(7'd8, 32'hAABBCCDD);
    w0 = wren_cnt;
    request(32'h20, 32'h11223344, 4'b0101);
    step(); // after E0
    checks++;
    if ({ram_rden, ram_wren, mem_ready, ram_rdaddr} !== {3'b100, 7'd8}) begin
      errors++; $display("FAIL pw_E0 got rd=%b wr=%b rdy=%b rdaddr=%0d exp 1 0 0 8", ram_rden, ram_wren, mem_ready, ram_rdaddr);
    end
    step(); // after E1
    checks++;
    if ({ram_rden, ram_wren, mem_ready} !== 3'b000) begin
      errors++; $display("FAIL pw_E1 got rd=%b wr=%b rdy=%b exp 000", ram_rden, ram_wren, mem_ready);
    end
    step(); // after E2
    checks++;
    if ({ram_wren, mem_ready, mem_err, ram_wraddr, ram_di} !== {3'b110, 7'd8, 32'hAA22CC44}) begin
      errors++; $display("FAIL pw_E2 got wr=%b rdy=%b err=%b wraddr=%0d di=%h exp 1 1 0 8 aa22cc44", ram_wren, mem_ready, mem_err, ram_wraddr, ram_di);
    end
    checks++;
    if (mem_rdata !== 32'h12345678) begin
      errors++; $display("FAIL pw_rdata_hold got %h exp 12345678", mem_rdata);
    end
    step(); // after E3
    mem_valid = 1'b0;
    checks++;
    if ({ram_wren, mem_ready, ram[8]} !== {2'b00, 32'hAA22CC44}) begin
      errors++; $display("FAIL pw_E3 got wr=%b rdy=%b ram8=%h exp 0 0 aa22cc44", ram_wren, mem_ready, ram[8]);
    end
    checks++;
    if (wren_cnt - w0 !== 1) begin
      errors++; $display("FAIL pw_wren_count got %0d exp 1", wren_cnt - w0);
    end
    step();
  endtask

  task automatic test_out_of_window();
    int r0, w0;
    r0 = ready_cnt; w0 = wren_cnt;
    request(32'h0001_0000, 32'h0, 4'h0);
    step(); // after E0
    checks++;
    if ({mem_ready, mem_err, ram_rden, ram_wren, mem_rdata} !== {4'b1100, 32'h0}) begin
      errors++; $display("FAIL oow_E0 got rdy=%b err=%b rd=%b wr=%b rdata=%h exp 1 1 0 0 0", mem_ready, mem_err, ram_rden, ram_wren, mem_rdata);
    end
    step(); // after E1
    mem_valid = 1'b0;
    checks++;
    if ({mem_ready, mem_err, ram_rden, ram_wren} !== 4'b0000) begin
      errors++; $display("FAIL oow_E1 got rdy=%b err=%b rd=%b wr=%b exp 0000", mem_ready, mem_err, ram_rden, ram_wren);
    end
    step(); step();
    checks++;
    if ({ready_cnt - r0, wren_cnt - w0} !== {32'd1, 32'd0}) begin
      errors++; $display("FAIL oow_counts got ready=%0d wren=%0d exp 1 0", ready_cnt - r0, wren_cnt - w0);
    end
  endtask

  task automatic test_reset_mid_op();
    int r0, w0;
    poke(7'd3, 32'h55555555);
    r0 = ready_cnt; w0 = wren_cnt;
    request(32'h0C, 32'h000000FF, 4'b0001);
    step(); // after E0, PW1
    step(); // after E1, PW2
    reset = 1'b1;
    step(); // after E2, reset sampled in PW2
    checks++;
    if ({mem_ready, mem_err, ram_wren, ram_rden, mem_rdata, ram_di, ram_wraddr, ram_rdaddr} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs got rdy=%b err=%b wr=%b rd=%b rdata=%h di=%h", mem_ready, mem_err, ram_wren, ram_rden, mem_rdata, ram_di);
    end
    reset = 1'b0; mem_valid = 1'b0;
    step(); step();
    checks++;
    if ({ram[3], ready_cnt - r0, wren_cnt - w0} !== {32'h55555555, 32'd0, 32'd0}) begin
      errors++; $display("FAIL rst_mid_abort got ram3=%h ready=%0d wren=%0d exp 55555555 0 0", ram[3], ready_cnt - r0, wren_cnt - w0);
    end
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = ready_cnt;
    request(32'h14, 32'h0, 4'h0);
    step(); step(); step(); // after E2
    checks++;
    if ({mem_ready, mem_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL b2b_first got rdy=%b rdata=%h exp 1 deadbeef", mem_ready, mem_rdata);
    end
    request(32'h20, 32'h0, 4'h0);
    step(); // after E3: turnaround, no accept
    checks++;
    if ({ram_rden, mem_ready} !== 2'b00) begin
      errors++; $display("FAIL b2b_turnaround got rd=%b rdy=%b exp 0 0", ram_rden, mem_ready);
    end
    step(); // after E4: second accept
    checks++;
    if ({ram_rden, ram_rdaddr} !== {1'b1, 7'd8}) begin
      errors++; $display("FAIL b2b_second_accept got rd=%b rdaddr=%0d exp 1 8", ram_rden, ram_rdaddr);
    end
    step(); step(); // after E6
    checks++;
    if ({mem_ready, mem_rdata} !== {1'b1, 32'hAA22CC44}) begin
      errors++; $display("FAIL b2b_second got rdy=%b rdata=%h exp 1 aa22cc44", mem_ready, mem_rdata);
    end
    step();
    mem_valid = 1'b0;
    step(); step(); step();
    checks++;
    if (ready_cnt - r0 !== 2) begin
      errors++; $display("FAIL b2b_ready_count got %0d exp 2", ready_cnt - r0);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_full_write();
    test_partial_write();
    test_out_of_window();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
